serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder_cell.sv | 20 ++
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned ADD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two XOR, two AND and one OR gate.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g;
  logic t;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign g    = a & b;
  assign t    = p & cin;
  assign cout = g | t;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell fed LSB first, carry recirculated through a flip-flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned N = ADD_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] S,
  output logic         Cout
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  ps_q, ps_d;
  logic [N-1:0]  s_q, s_d;
  logic          c_q, c_d;
  logic          co_q, co_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;
  logic load;
  logic last_bit;

  full_adder_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign load     = Start && (state_q != SHIFT);
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = Start ? SHIFT : IDLE;
      SHIFT:   state_d = last_bit ? DONE : SHIFT;
      DONE:    state_d = Start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == SHIFT);
    Done = (state_q == DONE);
  end

  // Partial sum fills from the MSB end so the last bit lands it fully aligned.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    ps_d  = ps_q;
    s_d   = s_q;
    co_d  = co_q;
    if (load) begin
      a_d   = A;
      b_d   = B;
      c_d   = Cin;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = fa_co;
      cnt_d = cnt_q + CW'(1);
      ps_d  = {fa_s, ps_q[N-1:1]};
      if (last_bit) begin
        s_d  = {fa_s, ps_q[N-1:1]};
        co_d = fa_co;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      ps_q  <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      s_q   <= s_d;
      co_q  <= co_d;
    end
  end

  assign S    = s_q;
  assign Cout = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver queues expected sums and Done times, monitor checks every cycle.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int unsigned N = ADD_W;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [N-1:0] S;
  logic         Cout;

  serial_adder #(.N(N)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [N:0]  sum;
    int unsigned done_cyc;
  } exp_t;

  exp_t       q[$];
  logic [N:0] hold = '0;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic       exp_busy;
  logic       exp_done;

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Expected behaviour derived from queued transactions: Busy for the N cycles before Done.
  always @(negedge Clk) begin
    if (mon_en) begin
      exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
      exp_busy = (q.size() > 0) && (cyc + N >= q[0].done_cyc) && (cyc < q[0].done_cyc);
      chk("busy", {{N{1'b0}}, Busy}, {{N{1'b0}}, exp_busy});
      chk("done", {{N{1'b0}}, Done}, {{N{1'b0}}, exp_done});
      if (exp_done) begin
        hold = q[0].sum;
        void'(q.pop_front());
      end
      chk("result", {Cout, S}, hold);
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    exp_t e;
    Start = 1'b1;
    A     = a;
    B     = b;
    Cin   = c;
    e.sum      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    e.done_cyc = cyc + 1 + N;
    q.push_back(e);
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // mode 0: quiet, 1: Start pulses on SHIFT cycles 2 and 5 with A=11, 2: Start held with random operands
  task automatic shift_phase(input int unsigned mode);
    for (int unsigned k = 0; k < N; k++) begin
      case (mode)
        1: begin
          Start = (k == 2) || (k == 5);
          A     = N'(8'h11);
          B     = N'($urandom);
        end
        2: begin
          Start = 1'b1;
          A     = N'($urandom);
          B     = N'($urandom);
          Cin   = 1'($urandom);
        end
        default: Start = 1'b0;
      endcase
      @(posedge Clk); #1;
    end
    Start = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    Start = 1'b0;
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    Rst   = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    issue(8'h5A, 8'h3C, 1'b0); shift_phase(0); idle(2);
    issue(8'hFF, 8'h01, 1'b0); shift_phase(0); idle(1);
    issue(8'hFF, 8'hFF, 1'b1); shift_phase(0); idle(1);
    issue(8'h12, 8'h34, 1'b0); shift_phase(1); idle(1);
    issue(8'h77, 8'h99, 1'b0); shift_phase(0);
    issue(8'h01, 8'h02, 1'b1); shift_phase(0); idle(1);

    issue(8'hC3, 8'h5A, 1'b1);
    idle(3);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    q.delete();
    hold = '0;
    idle(2);
    issue(8'h80, 8'h80, 1'b0); shift_phase(0); idle(1);

    issue(N'($urandom), N'($urandom), 1'($urandom)); shift_phase(2);
    issue(N'($urandom), N'($urandom), 1'($urandom)); shift_phase(2);
    issue(N'($urandom), N'($urandom), 1'($urandom)); shift_phase(0); idle(1);

    for (int i = 0; i < 40; i++) begin
      issue(N'($urandom), N'($urandom), 1'($urandom));
      shift_phase($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(N + 3);
    chk("drained", {{N{1'b0}}, (q.size() == 0)}, {{N{1'b0}}, 1'b1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
